// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ byte-stream
// requesters, holding the grant across a packet and aborting stuck owners.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TMR_W          = 18
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   timeout_err,
    output logic [2:0]             err_src
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_LOCK      = 2'd2;

    logic [1:0]         r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_owner;
    logic               r_last;
    logic [TMR_W-1:0]   r_timer;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_en;
    logic [7:0]         r_tx_data;
    logic               r_timeout_err;
    logic [2:0]         r_err_src;

    logic [7:0]         w_valid8;
    logic [7:0]         w_last8;
    logic [7:0]         w_byte [8];
    logic               w_found;
    logic [2:0]         w_win;
    logic [3:0]         w_idx;
    logic [2:0]         w_sel;
    logic               w_sel_ok;
    logic               w_offer;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_expire;
    logic [2:0]         w_next_ptr;

    // Pad requester vectors to 8 entries so a 3-bit index always selects exactly.
    always_comb begin
        w_valid8 = 8'(req_valid);
        w_last8  = 8'(req_last);
        for (int unsigned i = 0; i < 8; i++) begin
            w_byte[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_byte[i] = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(NUM_REQ)) begin
                w_idx = w_idx - 4'(NUM_REQ);
            end
            if (!w_found && w_valid8[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_sel    = r_owner;
        w_sel_ok = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel    = w_win;
                w_sel_ok = w_found;
            end
            S_LOCK: begin
                w_sel    = r_owner;
                w_sel_ok = 1'b1;
            end
            default: ;
        endcase
        w_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_onehot[i] = (w_sel == 3'(i));
        end
        w_offer   = PRESETn && w_sel_ok && !tx_busy;
        req_ready = w_offer ? w_onehot : '0;
        w_xfer    = w_offer && w_valid8[w_sel];
    end

    assign w_expire   = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_next_ptr = (r_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_owner + 3'd1;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_last        <= 1'b0;
            r_timer       <= '0;
            r_grant       <= '0;
            r_tx_en       <= 1'b0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
            r_err_src     <= '0;
        end else begin
            r_tx_en       <= 1'b0;
            r_timeout_err <= 1'b0;
            // A transfer can only occur in IDLE or LOCK, and it outranks expiry in LOCK.
            if (w_xfer) begin
                r_grant   <= w_onehot;
                r_owner   <= w_sel;
                r_tx_data <= w_byte[w_sel];
                r_last    <= w_last8[w_sel];
                r_tx_en   <= 1'b1;
                r_timer   <= '0;
                r_state   <= S_WAIT_DONE;
            end else begin
                case (r_state)
                    S_WAIT_DONE: begin
                        if (tx_done) begin
                            r_timer <= '0;
                            if (r_last) begin
                                r_grant <= '0;
                                r_ptr   <= w_next_ptr;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_LOCK;
                            end
                        end else if (w_expire) begin
                            r_timeout_err <= 1'b1;
                            r_err_src     <= r_owner;
                            r_grant       <= '0;
                            r_ptr         <= w_next_ptr;
                            r_timer       <= '0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_LOCK: begin
                        if (w_expire) begin
                            r_timeout_err <= 1'b1;
                            r_err_src     <= r_owner;
                            r_grant       <= '0;
                            r_ptr         <= w_next_ptr;
                            r_timer       <= '0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_IDLE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign grant       = r_grant;
    assign tx_en       = r_tx_en;
    assign tx_data     = r_tx_data;
    assign timeout_err = r_timeout_err;
    assign err_src     = r_err_src;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a scoreboard of expected bytes/grants is
// filled as requests are driven and drained at each tx_en pulse.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           PCLK = 1'b0;
    logic           PRESETn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;
    logic           timeout_err;
    logic [2:0]     err_src;

    typedef struct {
        logic [7:0]   data;
        logic [N-1:0] grant;
    } sb_t;

    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    always #5 PCLK = ~PCLK;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16),
        .TMR_W          (18)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .timeout_err (timeout_err),
        .err_src     (err_src)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [7:0] d, input logic last, input logic v);
        req_data[8*idx +: 8] = d;
        req_last[idx]        = last;
        req_valid[idx]       = v;
    endtask

    task automatic expect_byte(input logic [7:0] d, input int idx);
        sb_t          e;
        logic [N-1:0] one;
        one     = 1;
        e.data  = d;
        e.grant = one << idx;
        sb.push_back(e);
    endtask

    // Bounded wait for the next tx_en; compares the issued byte and owner to the scoreboard head.
    task automatic wait_issue(input string tag, input int max_cyc, output int waited);
        sb_t e;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (tx_en !== 1'b1 && waited < max_cyc);
        check({tag, "_tx_en"}, 32'(tx_en), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(tx_data), 32'(e.data));
            check({tag, "_grant"}, 32'(grant), 32'(e.grant));
        end
    endtask

    task automatic uart_finish(input int busy_cyc);
        tx_busy = 1'b1;
        repeat (busy_cyc) tick();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic reset_dut();
        PRESETn   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        tick();
        PRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int k;
        logic seen;

        PRESETn   = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_err_src", 32'(err_src), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        req_valid = '0;
        PRESETn   = 1'b1;

        // Single byte: one-cycle latency, grant held until tx_done.
        set_req(0, 8'hA5, 1'b1, 1'b1);
        expect_byte(8'hA5, 0);
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        wait_issue("t1", 4, w);
        check("t1_latency", 32'(w), 32'd1);
        req_valid[0] = 1'b0;
        tick();
        check("t1_pulse", 32'(tx_en), 32'd0);
        check("t1_grant_hold", 32'(grant), 32'b0001);
        uart_finish(3);
        check("t1_data_stable", 32'(tx_data), 32'hA5);
        check("t1_release", 32'(grant), 32'd0);

        // Round robin across all requesters, then ptr wraps to 0.
        reset_dut();
        for (int i = 0; i < N; i++) begin
            set_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
            expect_byte(8'(8'h10 + i), i);
        end
        for (int i = 0; i < N; i++) begin
            wait_issue($sformatf("t2_rr%0d", i), 4, w);
            check($sformatf("t2_latency%0d", i), 32'(w), 32'd1);
            req_valid[i] = 1'b0;
            uart_finish(2);
        end
        set_req(0, 8'h20, 1'b1, 1'b1);
        set_req(3, 8'h23, 1'b1, 1'b1);
        expect_byte(8'h20, 0);
        expect_byte(8'h23, 3);
        wait_issue("t2_wrap0", 4, w);
        req_valid[0] = 1'b0;
        uart_finish(2);
        wait_issue("t2_wrap3", 4, w);
        req_valid[3] = 1'b0;
        uart_finish(2);

        // Packet lock: req1 keeps the grant over three bytes while req2 waits.
        set_req(1, 8'h01, 1'b0, 1'b1);
        set_req(2, 8'h30, 1'b1, 1'b1);
        expect_byte(8'h01, 1);
        wait_issue("t3_b1", 4, w);
        set_req(1, 8'h02, 1'b0, 1'b1);
        expect_byte(8'h02, 1);
        uart_finish(2);
        check("t3_lock_grant", 32'(grant), 32'b0010);
        check("t3_lock_ready", 32'(req_ready), 32'b0010);
        wait_issue("t3_b2", 4, w);
        check("t3_lock_latency", 32'(w), 32'd1);
        set_req(1, 8'h03, 1'b1, 1'b1);
        expect_byte(8'h03, 1);
        uart_finish(2);
        wait_issue("t3_b3", 4, w);
        req_valid[1] = 1'b0;
        expect_byte(8'h30, 2);
        uart_finish(2);
        check("t3_release", 32'(grant), 32'd0);
        wait_issue("t3_req2", 4, w);
        req_valid[2] = 1'b0;
        uart_finish(2);

        // Watchdog abort of req3, then req0 wins over req3.
        set_req(3, 8'h44, 1'b1, 1'b1);
        expect_byte(8'h44, 3);
        wait_issue("t4_issue", 4, w);
        req_valid[3] = 1'b0;
        tx_busy = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (timeout_err !== 1'b1 && k < 24);
        check("t4_err_pulse", 32'(timeout_err), 32'd1);
        check("t4_err_latency", 32'(k), 32'd16);
        check("t4_err_src", 32'(err_src), 32'd3);
        check("t4_grant_clear", 32'(grant), 32'd0);
        tx_busy = 1'b0;
        tick();
        check("t4_err_once", 32'(timeout_err), 32'd0);
        set_req(0, 8'h50, 1'b1, 1'b1);
        set_req(3, 8'h53, 1'b1, 1'b1);
        expect_byte(8'h50, 0);
        expect_byte(8'h53, 3);
        wait_issue("t4_next0", 4, w);
        req_valid[0] = 1'b0;
        uart_finish(2);
        wait_issue("t4_next3", 4, w);
        req_valid[3] = 1'b0;
        uart_finish(2);

        // tx_done on the expiry cycle wins over the watchdog.
        set_req(0, 8'h66, 1'b1, 1'b1);
        expect_byte(8'h66, 0);
        wait_issue("t5_issue", 4, w);
        req_valid[0] = 1'b0;
        tx_busy = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        check("t5_no_early_err", 32'(seen), 32'd0);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t5_no_err", 32'(timeout_err), 32'd0);
        check("t5_release", 32'(grant), 32'd0);
        tick();
        check("t5_no_err_late", 32'(timeout_err), 32'd0);

        // Async reset during req2's WAIT_DONE; search restarts from requester 0.
        set_req(2, 8'h77, 1'b1, 1'b1);
        expect_byte(8'h77, 2);
        wait_issue("t6_issue", 4, w);
        req_valid[2] = 1'b0;
        tx_busy = 1'b1;
        tick();
        tick();
        set_req(0, 8'h80, 1'b1, 1'b1);
        set_req(2, 8'h82, 1'b1, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_tx_data", 32'(tx_data), 32'd0);
        check("t6_rst_tx_en", 32'(tx_en), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        tx_busy = 1'b0;
        tick();
        PRESETn = 1'b1;
        expect_byte(8'h80, 0);
        expect_byte(8'h82, 2);
        wait_issue("t6_first", 4, w);
        req_valid[0] = 1'b0;
        uart_finish(2);
        wait_issue("t6_second", 4, w);
        req_valid[2] = 1'b0;
        uart_finish(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
